// File: rtl/bcd_conv_arbiter.sv
// Shift-add-3 binary-to-BCD converter shared by two requesters through a round-robin arbiter.
// One input bit per clock; result pulses on out_valid and holds until the next result.
module bcd_conv_arbiter #(
  parameter int DATA_W = 19,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DATA_W-1:0]     req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  req1_ready,
  output logic                  out_valid,
  output logic                  out_id,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf,
  output logic                  busy
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]       bcd_q, bcd_adj, bcd_d;
  logic [CW-1:0]       cnt_q;
  logic                ovf_q, id_q, last_q;
  logic                out_valid_q, out_id_q, out_ovf_q;
  logic [BW-1:0]       out_bcd_q;
  logic                idle_rdy, gnt0, gnt1, hs;

  // last_q holds the index granted most recently; reset to 1 so req0 wins the first tie.
  assign idle_rdy   = (state_q == IDLE) && !rst;
  assign gnt0       = req0_valid && (!req1_valid || last_q);
  assign gnt1       = req1_valid && (!req0_valid || !last_q);
  assign req0_ready = idle_rdy && gnt0;
  assign req1_ready = idle_rdy && gnt1;
  assign hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d   = {bcd_adj[BW-2:0], shreg_q[DATA_W-1]};
    shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_bcd_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hs) begin
            shreg_q <= req1_ready ? req1_data : req0_data;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            id_q    <= req1_ready;
            last_q  <= req1_ready;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          shreg_q <= shreg_d;
          bcd_q   <= bcd_d;
          // A bit leaving the top digit means the value needs more digits than we have.
          ovf_q   <= ovf_q | bcd_adj[BW-1];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_W - 1)) state_q <= DONE;
        end
        DONE: begin
          out_valid_q <= 1'b1;
          out_bcd_q   <= ovf_q ? {DIGITS{4'h9}} : bcd_q;
          out_ovf_q   <= ovf_q;
          out_id_q    <= id_q;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_bcd   = out_bcd_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: default instance (19-bit) plus a 21-bit instance for overflow.
module tb_bcd_conv_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [18:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, out_valid, out_id, out_ovf, busy;
  logic [23:0] out_bcd;

  logic        r2_valid = 1'b0, r2b_valid = 1'b0;
  logic [20:0] r2_data = '0, r2b_data = '0;
  logic        r2_ready, r2b_ready, o2_valid, o2_id, o2_ovf, busy2;
  logic [23:0] o2_bcd;

  int n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_conv_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_id(out_id), .out_bcd(out_bcd), .out_ovf(out_ovf), .busy(busy));

  bcd_conv_arbiter #(.DATA_W(21), .DIGITS(6)) dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(r2_valid), .req0_data(r2_data), .req0_ready(r2_ready),
    .req1_valid(r2b_valid), .req1_data(r2b_data), .req1_ready(r2b_ready),
    .out_valid(o2_valid), .out_id(o2_id), .out_bcd(o2_bcd), .out_ovf(o2_ovf), .busy(busy2));

  // Reference: decimal digits by division; anything above 999999 saturates.
  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned t;
    r = '0;
    if (v > 999999) return 24'h999999;
    t = v;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (req0_ready || req1_ready) chk("one_ready_only", 32'(req0_ready & req1_ready), 32'd0);
  end

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input bit which, input int unsigned val);
    bit ok;
    ok = 1'b0;
    if (which) begin req1_valid = 1'b1; req1_data = 19'(val); end
    else       begin req0_valid = 1'b1; req0_data = 19'(val); end
    #1;
    for (int i = 0; i < 100; i++) begin
      if ((which && req1_ready) || (!which && req0_ready)) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    chk("grant_seen", 32'(ok), 32'd1);
    @(negedge clk);
    acc_cyc = cyc;
    if (which) begin req1_valid = 1'b0; req1_data = 19'($urandom); end
    else       begin req0_valid = 1'b0; req0_data = 19'($urandom); end
  endtask

  task automatic wait_out(output int lat, output int bcnt);
    bit ok;
    ok = 1'b0; bcnt = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      if (busy) bcnt++;
      @(negedge clk);
    end
    lat = cyc - acc_cyc;
    chk("out_valid_seen", 32'(ok), 32'd1);
  endtask

  task automatic conv2(input int unsigned val);
    bit ok;
    ok = 1'b0;
    r2_valid = 1'b1; r2_data = 21'(val);
    #1;
    for (int i = 0; i < 100; i++) begin
      if (r2_ready) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
    @(negedge clk);
    r2_valid = 1'b0;
    for (int i = 0; i < 80 && ok; i++) begin
      if (o2_valid) break;
      @(negedge clk);
    end
    chk("ovf_inst_valid", 32'(o2_valid), 32'd1);
    chk("ovf_inst_bcd", 32'(o2_bcd), 32'(ref_bcd(val)));
    chk("ovf_inst_flag", 32'(o2_ovf), 32'(val > 999999));
  endtask

  typedef struct {
    bit          id;
    int unsigned val;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[5];
  int lat, bcnt, seen;
  bit which;
  int unsigned v, a0, a1;

  initial begin
    vecs[0] = '{1'b0, 0,      24'h000000};
    vecs[1] = '{1'b1, 99999,  24'h099999};
    vecs[2] = '{1'b0, 100000, 24'h100000};
    vecs[3] = '{1'b1, 1,      24'h000001};
    vecs[4] = '{1'b1, 524287, 24'h524287};

    // Reset with both requesters waiting: nothing may be granted while rst is high.
    req0_valid = 1'b1; req0_data = 19'd524287;
    req1_valid = 1'b1; req1_data = 19'd1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_id", 32'(out_id), 0);
    chk("rst_out_bcd", 32'(out_bcd), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready0", 32'(req0_ready), 0);
    chk("rst_ready1", 32'(req1_ready), 0);
    rst = 1'b0; req1_valid = 1'b0;
    #1;
    chk("post_rst_ready0", 32'(req0_ready), 1);
    @(negedge clk);
    acc_cyc = cyc; req0_valid = 1'b0;
    wait_out(lat, bcnt);
    chk("max_bcd", 32'(out_bcd), 32'h524287);
    chk("max_id", 32'(out_id), 0);
    chk("max_ovf", 32'(out_ovf), 0);
    chk("max_latency", 32'(lat), 20);
    chk("max_busy_cycles", 32'(bcnt), 20);
    @(negedge clk);
    chk("valid_one_cycle", 32'(out_valid), 0);
    chk("bcd_holds", 32'(out_bcd), 32'h524287);

    foreach (vecs[k]) begin
      send(vecs[k].id, vecs[k].val);
      wait_out(lat, bcnt);
      chk("vec_bcd", 32'(out_bcd), 32'(vecs[k].exp));
      chk("vec_id", 32'(out_id), 32'(vecs[k].id));
      chk("vec_latency", 32'(lat), 20);
    end

    // Both requesters held valid from reset: grants must alternate starting with req0.
    rst = 1'b1;
    a0 = 1234; a1 = 56789;
    req0_valid = 1'b1; req0_data = 19'(a0);
    req1_valid = 1'b1; req1_data = 19'(a1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 4; g++) begin
      #1;
      for (int i = 0; i < 60 && !(req0_ready || req1_ready); i++) begin
        @(negedge clk); #1;
      end
      chk("arb_grant1", 32'(req1_ready), 32'(g % 2));
      chk("arb_grant0", 32'(req0_ready), 32'((g + 1) % 2));
      @(negedge clk);
      acc_cyc = cyc;
      wait_out(lat, bcnt);
      chk("arb_id", 32'(out_id), 32'(g % 2));
      chk("arb_bcd", 32'(out_bcd), 32'(ref_bcd((g % 2) ? a1 : a0)));
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);

    // Random sweep; data is scrambled after each handshake and must not matter.
    for (int n = 0; n < 1000; n++) begin
      which = 1'($urandom);
      v = $urandom_range(0, 524287);
      send(which, v);
      wait_out(lat, bcnt);
      chk("rand_bcd", 32'(out_bcd), 32'(ref_bcd(v)));
      chk("rand_id", 32'(out_id), 32'(which));
      chk("rand_ovf", 32'(out_ovf), 0);
    end

    // Abort mid-conversion; last grant was req0, so only a reset restores req0 priority.
    @(negedge clk);
    send(1'b0, 4321);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("abort_no_valid", 32'(seen), 0);
    req0_valid = 1'b1; req0_data = 19'd4321;
    req1_valid = 1'b1; req1_data = 19'd777;
    #1;
    chk("abort_ptr_ready0", 32'(req0_ready), 1);
    chk("abort_ptr_ready1", 32'(req1_ready), 0);
    @(negedge clk);
    acc_cyc = cyc; req0_valid = 1'b0; req1_valid = 1'b0;
    wait_out(lat, bcnt);
    chk("abort_next_bcd", 32'(out_bcd), 32'h004321);
    chk("abort_next_id", 32'(out_id), 0);

    // Overflow on the 21-bit instance, then sticky must clear on the next value.
    @(negedge clk);
    conv2(1500000);
    @(negedge clk);
    conv2(999999);
    @(negedge clk);
    conv2(2097151);
    @(negedge clk);
    conv2(1000000);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      conv2($urandom_range(0, 2097151));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks done", n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Sequential binary-to-BCD converter (shift-add-3, one bit per clock) shared between two requesters, e.g. the ultrasonic distance path and the speed display path.
- Replaces wide combinational divide/modulo digit extraction with a small iterative datapath.
- A round-robin arbiter grants the converter, and valid/ready handshakes sit on both sides.
- Output drives the 6-digit display formatter: hundreds-cm down to 0.01 mm for distance.

Parameters:
- DATA_W, 19, width of the binary input value.
- DIGITS, 6, number of BCD output digits. out_bcd width is 4*DIGITS.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  synchronous reset, active-high
- req0_valid  input  1  requester 0 has a value to convert
- req0_data  input  DATA_W  requester 0 binary value
- req0_ready  output  1  converter accepts requester 0 this cycle
- req1_valid  input  1  requester 1 has a value to convert
- req1_data  input  DATA_W  requester 1 binary value
- req1_ready  output  1  converter accepts requester 1 this cycle
- out_valid  output  1  one-cycle pulse: out_bcd, out_id and out_ovf are new
- out_id  output  1  requester index that owns the current result
- out_bcd  output  4*DIGITS  BCD result; [4*DIGITS-1 -: 4] is the most-significant digit (hundreds-cm for distance), [3:0] the least-significant
- out_ovf  output  1  value exceeded 10^DIGITS-1; out_bcd saturated to all 9s
- busy  output  1  conversion in progress (state != IDLE)

Behaviour:
- Clock and reset: clk only. rst is synchronous and active-high; all flops update on posedge clk.
- Reset values: out_valid=0, out_id=0, out_bcd=0, out_ovf=0, busy=0, both readys=0 during reset. Round-robin pointer prefers req0. State=IDLE, shift counter=0.
- Asserting rst mid-conversion aborts the conversion with no out_valid. The converter is ready on the first cycle after rst deasserts.
- States:
  - IDLE: busy=0. Readys are combinational from the arbiter; at most one is high.
    - Only one valid: grant that requester.
    - Both valid: grant the requester not granted last; first grant after reset goes to req0.
    - Neither valid: both readys low, stay in IDLE.
  - IDLE handshake (valid&ready at an edge): capture data into the shift register, clear the BCD accumulator and overflow sticky, store the grant index, go to SHIFT.
  - SHIFT: DATA_W cycles, one per input bit, MSB first.
    - Each cycle: every BCD digit >=5 gets +3 first, then {bcd, shreg} shifts left by 1.
    - A 1 shifted out of the top digit sets the overflow sticky.
    - After the DATA_W-th shift, go to DONE.
  - DONE: one cycle.
    - out_valid=1. out_bcd = accumulator, or all 9s if the sticky is set. out_ovf = sticky. out_id = stored index.
    - Go to IDLE. Readys stay low in DONE.
- Latency: accept at edge T; out_valid is high in the cycle after edge T+DATA_W+1 (20 edges at default). Peak throughput is one result per DATA_W+2 cycles.
- out_bcd, out_id and out_ovf hold their values until the next DONE. out_valid deasserts after one cycle.
- There is no output backpressure; the consumer must sample on out_valid.
- Requesters must hold data stable while valid && !ready. Data is sampled only at the handshake edge. Changing req*_data during SHIFT has no effect.
- Valid raised during SHIFT or DONE waits in IDLE for arbitration. A requester may drop valid before it is granted; no request is remembered.
- Round-robin pointer updates only on a handshake, to the index just granted.
- Default configuration cannot overflow (max 524287 < 999999). out_ovf only matters when DATA_W > log2(10^DIGITS).

Test Plan:
- Reset: assert rst for 3 cycles mid-idle.
  -> All outputs 0, busy=0. First cycle after release with req0_valid=1: req0_ready=1.
- Single conversion: req0 sends 524287.
  -> out_valid 20 edges after accept. out_bcd=0x524287, out_id=0, out_ovf=0. busy high for exactly 20 cycles.
- Boundary values:
  - 0 -> 0x000000
  - 99999 -> 0x099999
  - 100000 -> 0x100000
  - 1 -> 0x000001
  - Random sweep of 1000 values checked against a reference model.
- Arbitration: both valid continuously after reset with values 1234 (req0) and 56789 (req1).
  -> Grants alternate 0,1,0,1. Results 0x001234/id0 and 0x056789/id1. Never two readys high in one cycle.
- Reset mid-operation: assert rst at SHIFT cycle 7.
  -> No out_valid. Next request converts correctly. Arbiter pointer back to req0 priority.
- Overflow: DATA_W=21, DIGITS=6, input 1500000.
  -> out_bcd=0x999999, out_ovf=1. Following input 999999 gives out_ovf=0 (sticky cleared).
